// File: rtl/pwm_duty_sequencer_if.sv
// Ramp command handshake between a requester and pwm_duty_sequencer.
interface pwm_duty_sequencer_if #(
    parameter int DUTY_W = 4,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_target;
    logic [STEP_W-1:0] cmd_step;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_step,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Ramps the pwm_gen duty word toward a commanded target, one LSB per
// step, updating only on PWM period boundaries.
module pwm_duty_sequencer #(
    parameter int DUTY_W      = 4,
    parameter int PERIOD_CLKS = 15,
    parameter int STEP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_duty_sequencer_if.slave cmd,
    input  logic              abort,
    output logic [DUTY_W-1:0] pwm_duty,
    output logic              period_start,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CLKS - 1);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ps_q;
    logic              done_q, done_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DUTY_W-1:0] duty_step;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] scnt_q, scnt_d;
    logic              boundary;
    logic              accept;
    logic              upd;
    logic              reached;
    logic              ready;

    // Free-running period counter, independent of the FSM.
    assign boundary = (cnt_q == CNT_LAST);
    assign cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);

    assign accept = cmd.cmd_valid && ready;
    assign upd    = (state_q == RAMP) && !abort && boundary;

    always_comb begin
        tgt_d     = tgt_q;
        step_d    = step_q;
        scnt_d    = scnt_q;
        duty_d    = duty_q;
        duty_step = (tgt_q > duty_q) ? duty_q + DUTY_W'(1)
                                     : duty_q - DUTY_W'(1);
        if (accept) begin
            tgt_d  = cmd.cmd_target;
            step_d = cmd.cmd_step;
            scnt_d = cmd.cmd_step;
        end else if (upd) begin
            if (step_q == '0) begin
                duty_d = tgt_q;
            end else if (scnt_q == STEP_W'(1)) begin
                duty_d = duty_step;
                scnt_d = step_q;
            end else begin
                scnt_d = scnt_q - STEP_W'(1);
            end
        end
    end

    assign reached = upd && (duty_d == tgt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd.cmd_target == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (reached) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == RAMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ps_q   <= 1'b0;
            done_q <= 1'b0;
            duty_q <= '0;
            tgt_q  <= '0;
            step_q <= '0;
            scnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ps_q   <= boundary;
            done_q <= done_d;
            duty_q <= duty_d;
            tgt_q  <= tgt_d;
            step_q <= step_d;
            scnt_q <= scnt_d;
        end
    end

    assign cmd.cmd_ready = ready;
    assign pwm_duty      = duty_q;
    assign period_start  = ps_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed and randomized ramp commands checked every cycle against
// an arithmetic model of the duty trajectory.
module tb_pwm_duty_sequencer;

    localparam int DW = 4;
    localparam int SW = 8;
    localparam int PC = 15;
    localparam int TMO = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] pwm_duty;
    logic          period_start;
    logic          busy;
    logic          done;

    pwm_duty_sequencer_if #(.DUTY_W(DW), .STEP_W(SW)) cif ();

    pwm_duty_sequencer #(
        .DUTY_W(DW),
        .PERIOD_CLKS(PC),
        .STEP_W(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cif.slave),
        .abort(abort),
        .pwm_duty(pwm_duty),
        .period_start(period_start),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycles since reset release, and the active ramp as
    // (start duty, target, step, boundaries elapsed).
    int ncyc;
    int m_duty, m_d0, m_t, m_s, m_nb;
    bit m_busy, e_done, e_ps;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("duty", {28'd0, pwm_duty}, m_duty);
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("ready", {31'd0, cif.cmd_ready}, {31'd0, !m_busy});
        check("done", {31'd0, done}, {31'd0, e_done});
        check("pstart", {31'd0, period_start}, {31'd0, e_ps});
    endtask

    task automatic model_reset();
        ncyc   = 0;
        m_duty = 0;
        m_busy = 0;
        e_done = 0;
        e_ps   = 0;
    endtask

    task automatic tick();
        bit v, ab, bnd;
        int tg, st;
        v   = cif.cmd_valid;
        ab  = abort;
        tg  = int'(cif.cmd_target);
        st  = int'(cif.cmd_step);
        bnd = (ncyc % PC) == PC - 1;
        @(posedge clk);
        e_done = 0;
        e_ps   = bnd;
        if (!m_busy) begin
            if (v) begin
                if (tg == m_duty) begin
                    e_done = 1;
                end else begin
                    m_busy = 1;
                    m_d0   = m_duty;
                    m_t    = tg;
                    m_s    = st;
                    m_nb   = 0;
                end
            end
        end else if (ab) begin
            m_busy = 0;
        end else if (bnd) begin
            m_nb++;
            if (m_s == 0) m_duty = m_t;
            else if (m_t > m_d0) m_duty = m_d0 + m_nb / m_s;
            else m_duty = m_d0 - m_nb / m_s;
            if (m_duty == m_t) begin
                m_busy = 0;
                e_done = 1;
            end
        end
        ncyc++;
        #1 check_all();
    endtask

    task automatic send(input int t, input int s);
        cif.cmd_valid  = 1'b1;
        cif.cmd_target = DW'(t);
        cif.cmd_step   = SW'(s);
        tick();
        cif.cmd_valid  = 1'b0;
    endtask

    task automatic run_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < TMO) begin
            tick();
            n++;
        end
        check(tag, n < TMO, 1);
    endtask

    task automatic run_duty(input int v, input string tag);
        int n = 0;
        while (pwm_duty !== DW'(v) && n < TMO) begin
            tick();
            n++;
        end
        check(tag, n < TMO, 1);
    endtask

    initial begin
        cif.cmd_valid  = 1'b0;
        cif.cmd_target = '0;
        cif.cmd_step   = '0;
        rst_n = 1'b0;
        model_reset();
        #12 check_all();
        @(negedge clk) rst_n = 1'b1;

        // Up-ramp 0 -> 6, one LSB per period.
        send(6, 1);
        run_idle("ramp_up_to");
        repeat (3) tick();

        // Jump to 13, then down-ramp every two periods.
        send(13, 0);
        run_idle("jump13_to");
        send(2, 2);
        run_idle("ramp_dn_to");

        // Direct jump and already-at-target command.
        send(15, 0);
        run_idle("jump15_to");
        tick();
        send(15, 3);
        tick();
        send(0, 0);
        run_idle("jump0_to");

        // Abort at duty 4 with an ignored command mid-ramp.
        send(13, 1);
        run_duty(2, "wait2_to");
        cif.cmd_valid  = 1'b1;
        cif.cmd_target = DW'(7);
        tick();
        cif.cmd_valid  = 1'b0;
        run_duty(4, "wait4_to");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        send(9, 1);
        run_idle("ramp9_to");

        // Abort exactly on a boundary cycle.
        send(0, 1);
        run_duty(8, "wait8_to");
        while ((ncyc % PC) != PC - 1) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        // Abort in IDLE is ignored; with cmd_valid the command wins.
        abort = 1'b1;
        tick();
        send(3, 0);
        abort = 1'b0;
        run_idle("abort_idle_to");

        // Randomized commands with sparse aborts and ignored requests.
        for (int k = 0; k < 14; k++) begin
            int n;
            send($urandom_range(0, 15), $urandom_range(0, 3));
            n = 0;
            while (busy !== 1'b0 && n < TMO) begin
                abort          = ($urandom_range(0, 49) == 0);
                cif.cmd_valid  = ($urandom_range(0, 9) == 0);
                cif.cmd_target = DW'($urandom_range(0, 15));
                tick();
                n++;
            end
            abort         = 1'b0;
            cif.cmd_valid = 1'b0;
            check("rand_to", n < TMO, 1);
            repeat ($urandom_range(0, 20)) tick();
        end

        // Asynchronous reset mid-ramp, off the clock edge.
        send(12, 1);
        repeat (20) tick();
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;
        repeat (17) tick();
        send(5, 2);
        run_idle("post_rst_to");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Controller that drives the pwm_duty input of pwm_gen. It accepts ramp commands (target duty, periods per step) over a valid/ready handshake. It moves the duty one LSB at a time toward the target, changing it only on PWM period boundaries so the generator never sees a mid-period glitch. It also exports a period-start strobe for downstream logic.

Parameters:
DUTY_W, 4, width of duty word; matches pwm_gen duty input
PERIOD_CLKS, 15, clk cycles per PWM period; must equal pwm_gen pwm_period_base_clk
STEP_W, 8, width of cmd_step (PWM periods per duty LSB)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_target  in  DUTY_W  target duty
cmd_step  in  STEP_W  PWM periods per LSB step; 0 = jump directly to target
abort  in  1  stop ramp, hold current duty
pwm_duty  out  DUTY_W  duty value fed to pwm_gen
period_start  out  1  one-cycle strobe, first clk of each PWM period
busy  out  1  ramp in progress
done  out  1  one-cycle pulse on ramp completion

Behaviour:
- Reset (rst_n low, async):
  - pwm_duty=0, busy=0, done=0, period_start=0, cmd_ready=1.
  - Period counter cleared to 0; state IDLE.
  - Reset mid-ramp discards the command.
- Period counter:
  - Free-running 0..PERIOD_CLKS-1, wraps to 0.
  - Boundary = cycle where counter==PERIOD_CLKS-1.
  - period_start is registered: it is 1 in every cycle where counter==0, except the first cycle after reset release.
- Timing: all duty updates are registered on the boundary edge, so the new duty is valid from the first clk of the next period (the same cycle period_start is high).
- States: IDLE, RAMP.
- IDLE:
  - cmd_ready=1.
  - Accept when cmd_valid && cmd_ready; latch target and step.
  - If target==pwm_duty: done=1 in the next cycle, stay IDLE.
  - Otherwise: go to RAMP, busy=1 and cmd_ready=0 from the next cycle; load the step counter with cmd_step.
- RAMP:
  - Only boundaries strictly after the accept cycle count.
  - cmd_step=S>=1: decrement the step counter at each boundary. When it reaches 0, move pwm_duty ±1 toward the target and reload with S. The duty changes every S periods.
  - cmd_step=0: at the first boundary, pwm_duty is set to the target.
  - When the updated pwm_duty equals the target: next cycle is IDLE, busy=0, cmd_ready=1, done=1 for exactly one cycle.
- Ramp length: from d0 to t takes |t-d0|*max(S,1) boundaries (1 boundary when S=0).
- Arithmetic: the duty moves only toward the latched target, never past it, so 0 and 2^DUTY_W-1 are never crossed and the duty never wraps.
- Command while busy: cmd_valid is ignored in RAMP and not queued; the requester holds cmd_valid until cmd_ready.
- abort:
  - In RAMP: next cycle is IDLE, pwm_duty frozen at its current value, busy=0, cmd_ready=1, no done pulse.
  - abort on a boundary cycle: abort wins, and no step is applied that cycle.
  - In IDLE: ignored. abort and cmd_valid together in IDLE: the command is accepted.
- The period counter is never reset by commands or abort; it runs independently of the state machine.

Test Plan:
1. Reset, then cmd target=6 step=1 at duty 0 -> pwm_duty steps 1,2,...,6 on 6 consecutive boundaries (15 clk apart), each coincident with period_start; done pulses once in the cycle after duty=6; busy is high throughout.
2. From duty 13, cmd target=2 step=2 -> duty decrements every 2 periods; 11 steps reach 2 after 22 boundaries (330 clk); no value below 2 appears.
3. From duty 2, cmd target=15 step=0 -> pwm_duty=15 at the first boundary after accept, done the next cycle; duty equals target on accept -> done one cycle later, no duty change, busy stays 0.
4. Ramp 0->13 step=1; assert abort when duty=4 (also once exactly on a boundary) -> duty holds 4, busy=0, no done; cmd_valid pulsed during the ramp is ignored; a new command is accepted in the cycle after the abort.
5. rst_n driven low mid-ramp at a non-clock-edge time -> outputs go to reset values immediately; after release, period_start first appears after one full period and a fresh command ramps from 0.
